shift_deserializer: RTL and testbench

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_bit_counter.sv | 31 +++
 rtl/shift_deserializer.sv | 139 +++++++++++++
 tb/tb_shift_deserializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the serial-to-parallel deserializer
//   DIR_MSB_FIRST / DIR_LSB_FIRST : values of the dir input
//   state_t                       : deserializer FSM states
package shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_PARITY  = 2'b01,
        ST_HOLD    = 2'b10
    } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - accepted-bit counter with clear and terminal flag
//   clk, rst : clock, asynchronous active-high reset
//   clr      : return count to 0 (wins over inc)
//   inc      : advance count by one
//   count    : current bit index 0..WIDTH-1
//   last     : count == WIDTH-1
module shift_bit_counter #(
    parameter int WIDTH = 4,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial bit stream to WIDTH-bit word, optional even parity
//   optional feature macro: SHIFT_DESER_PARITY_EN (one trailing even-parity bit per word)
//   clk, rst              : clock, asynchronous active-high reset
//   dir                   : 0 MSB-first, 1 LSB-first; sampled on the first bit of a word
//   sin, sin_valid        : serial bit and its qualifier
//   sin_ready             : bit accepted when sin_valid & sin_ready
//   dout, dout_valid      : assembled word, valid while holding
//   dout_ready            : consumer takes dout
//   perr                  : parity error for the held word (0 without parity)
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             perr
);

    import shift_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sreg;
    logic             dir_q;
    logic             dir_eff;
    logic             accept;
    logic             take_data;
    logic             first_bit;
    logic             handshake;
    logic             cnt_clr;
    logic [CW-1:0]    cnt;
    logic             cnt_last;

    // sin_ready is low only in HOLD, so acceptance is derived from state
    // directly rather than through the output to keep the comb path flat.
    assign accept    = sin_valid && (state != ST_HOLD);
    assign take_data = accept && (state == ST_COLLECT);
    assign first_bit = (cnt == '0);
    assign handshake = (state == ST_HOLD) && dout_ready;

    // The first bit of a word uses the live dir; later bits use the latch.
    assign dir_eff   = first_bit ? dir : dir_q;
    assign cnt_clr   = (take_data && cnt_last) || handshake;

    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (take_data),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        sin_ready  = 1'b1;
        dout_valid = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (take_data && cnt_last) begin
`ifdef SHIFT_DESER_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_HOLD;
`endif
                end
            end
`ifdef SHIFT_DESER_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    state_n = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                sin_ready  = 1'b0;
                dout_valid = 1'b1;
                if (dout_ready) begin
                    state_n = ST_COLLECT;
                end
            end
            default: begin
                state_n = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (take_data) begin
            if (first_bit) begin
                dir_q <= dir;
            end
            if (dir_eff == DIR_LSB_FIRST) begin
                sreg <= {sin, sreg[WIDTH-1:1]};
            end else begin
                sreg <= {sreg[WIDTH-2:0], sin};
            end
        end
    end

    assign dout = sreg;

`ifdef SHIFT_DESER_PARITY_EN
    logic perr_q;

    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (accept && (state == ST_PARITY)) begin
            perr_q <= (^sreg) ^ sin;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - self-checking bench for shift_deserializer
module tb_shift_deserializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             dir;
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             perr;

    int checks;
    int failures;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .dir        (dir),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .perr       (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // seq[i] is the i-th bit sent on the wire.
    function automatic logic [WIDTH-1:0] model_word(input logic [WIDTH-1:0] seq, input logic d);
        int w;
        w = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d == 1'b0) w = w + (int'(seq[i]) * (2 ** (WIDTH - 1 - i)));
            else           w = w + (int'(seq[i]) * (2 ** i));
        end
        return WIDTH'(w);
    endfunction

    function automatic logic model_perr(input logic [WIDTH-1:0] seq, input logic par);
`ifdef SHIFT_DESER_PARITY_EN
        int ones;
        ones = int'(par);
        for (int i = 0; i < WIDTH; i++) ones = ones + int'(seq[i]);
        return (ones % 2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Sends one word, optionally with a sin_valid gap before bit gap_at and
    // a back-pressure stretch of hold cycles, then checks the result.
    task automatic send_word(input string tag, input logic [WIDTH-1:0] seq, input logic d,
                             input logic toggle, input int gap_at, input int gap,
                             input logic par, input int hold);
        logic [WIDTH-1:0] exp_w;
        logic             exp_p;
        exp_w = model_word(seq, d);
        exp_p = model_perr(seq, par);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    sin_valid = 1'b0;
                    sin       = 1'($urandom);
                    dir       = 1'($urandom);
                end
            end
            @(negedge clk);
            check({tag, "_rdy"}, 32'(sin_ready), 32'd1);
            check({tag, "_vld_lo"}, 32'(dout_valid), 32'd0);
            sin_valid = 1'b1;
            sin       = seq[i];
            if (i == 0)      dir = d;
            else if (toggle) dir = ~d;
            else             dir = 1'($urandom);
        end
`ifdef SHIFT_DESER_PARITY_EN
        @(negedge clk);
        check({tag, "_par_rdy"}, 32'(sin_ready), 32'd1);
        check({tag, "_par_vld_lo"}, 32'(dout_valid), 32'd0);
        sin_valid = 1'b1;
        sin       = par;
        dir       = 1'($urandom);
`endif
        @(negedge clk);
        sin_valid = 1'b0;
        check({tag, "_vld"}, 32'(dout_valid), 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(exp_w));
        check({tag, "_perr"}, 32'(perr), 32'(exp_p));
        for (int k = 0; k < hold; k++) begin
            dout_ready = 1'b0;
            sin_valid  = 1'b1;
            sin        = 1'($urandom);
            @(negedge clk);
            check({tag, "_hold_vld"}, 32'(dout_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(sin_ready), 32'd0);
            check({tag, "_hold_dout"}, 32'(dout), 32'(exp_w));
            check({tag, "_hold_perr"}, 32'(perr), 32'(exp_p));
        end
        // Handshake cycle: a valid bit offered here must not be taken.
        dout_ready = 1'b1;
        sin_valid  = 1'b1;
        sin        = 1'($urandom);
        @(negedge clk);
        check({tag, "_vld_pulse"}, 32'(dout_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(sin_ready), 32'd1);
        sin_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        dir        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        dout_ready = 1'b1;
        #1;
        check("rst_rdy", 32'(sin_ready), 32'd1);
        check("rst_vld", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1,0,1,1 MSB-first -> 1011, immediate consume
        send_word("msb", 4'b1101, 1'b0, 1'b0, WIDTH, 0, 1'b1, 0);
        // 1,0,1,1 LSB-first -> 1101, and again with dir toggled after bit 1
        send_word("lsb", 4'b1101, 1'b1, 1'b0, WIDTH, 0, 1'b1, 0);
        send_word("lsb_tog", 4'b1101, 1'b1, 1'b1, WIDTH, 0, 1'b1, 0);
        // back-pressure for 3 cycles, then next word must be intact
        send_word("bp", 4'b0011, 1'b0, 1'b0, WIDTH, 0, 1'b0, 3);
        send_word("bp_next", 4'b1010, 1'b0, 1'b0, WIDTH, 0, 1'b0, 0);
        // 5 idle cycles between bits 2 and 3
        send_word("gap", 4'b1101, 1'b0, 1'b0, 2, 5, 1'b1, 0);
        // parity bit 1 (good) and 0 (bad) on 1,0,1,1
        send_word("par_ok", 4'b1101, 1'b0, 1'b0, WIDTH, 0, 1'b1, 1);
        send_word("par_bad", 4'b1101, 1'b0, 1'b0, WIDTH, 0, 1'b0, 1);

        // reset after two accepted bits discards the partial word
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sin_valid = 1'b1;
            sin       = 1'b1;
            dir       = 1'b0;
        end
        @(negedge clk);
        sin_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(sin_ready), 32'd1);
        check("mid_rst_vld", 32'(dout_valid), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_vld", 32'(dout_valid), 32'd0);
        send_word("post_rst", 4'b0110, 1'b0, 1'b0, WIDTH, 0, 1'b0, 0);

        // randomized words against the model
        for (int n = 0; n < 40; n++) begin
            send_word("rnd", WIDTH'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, WIDTH)), int'($urandom_range(0, 3)),
                      1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
